// File: rtl/scaler_vpos_gen.sv
// Vertical position generator for the output scaler: maps output-line timing onto
// a source-line index plus an 8-bit fractional position within that source line.
module scaler_vpos_gen #(
   parameter int SRC_W = 10
) (
   input  logic             mclk,
   input  logic             nrst,
   input  logic             vsync_i,
   input  logic             hsync_i,
   input  logic [10:0]      cfg_vstart,
   input  logic [10:0]      cfg_vactive,
   input  logic [15:0]      cfg_vinc,
   input  logic [7:0]       cfg_vphase,
   input  logic [SRC_W-1:0] cfg_src_lines,
   output logic             line_start_o,
   output logic             line_active_o,
   output logic [SRC_W-1:0] src_line_o,
   output logic [7:0]       scale_vpos_rel_o,
   output logic             frame_done_o
);

   localparam int ACC_W = SRC_W + 8;

   typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [10:0]        vstart_q, vstart_d;
   logic [10:0]        vactive_q, vactive_d;
   logic [15:0]        vinc_q, vinc_d;
   logic [SRC_W-1:0]   src_lines_q, src_lines_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [10:0]        lcnt_q, lcnt_d;
   logic               line_start_q, line_start_d;
   logic               line_active_q, line_active_d;
   logic               frame_done_q, frame_done_d;
   logic [SRC_W-1:0]   src_line_q, src_line_d;
   logic [7:0]         vpos_q, vpos_d;

   logic               hs_evt;
   logic               start_hit;
   logic               end_hit;
   logic               line_go;
   logic               term;
   logic [ACC_W-1:0]   pos_clamped;

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [15:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {{(ACC_W-15){1'b0}}, b};
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

   // Integer part at or past the last source line pins to that line with zero fraction.
   function automatic logic [ACC_W-1:0] clamp_pos(input logic [ACC_W-1:0] a,
                                                  input logic [SRC_W-1:0] lines);
      logic [SRC_W-1:0] last;
      last = lines - {{(SRC_W-1){1'b0}}, 1'b1};
      if (lines == '0)
         return '0;
      else if (a[ACC_W-1:8] >= last)
         return {last, 8'h00};
      else
         return a;
   endfunction

   // vsync has priority, so an hsync in the same cycle is discarded.
   assign hs_evt      = hsync_i & ~vsync_i;
   assign start_hit   = (state_q == S_VBLANK) && (lcnt_q == vstart_q);
   assign end_hit     = (state_q == S_ACTIVE) && (lcnt_q == vactive_q);
   assign line_go     = hs_evt && ((start_hit && (vactive_q != '0)) ||
                                   ((state_q == S_ACTIVE) && !end_hit));
   assign term        = hs_evt && ((start_hit && (vactive_q == '0)) || end_hit);
   assign pos_clamped = clamp_pos(acc_q, src_lines_q);

   always_ff @(posedge mclk or negedge nrst) begin
      if (!nrst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (vsync_i)
         state_d = S_VBLANK;
      else if (term)
         state_d = S_DONE;
      else if (line_go)
         state_d = S_ACTIVE;
   end

   always_comb begin
      vstart_d      = vstart_q;
      vactive_d     = vactive_q;
      vinc_d        = vinc_q;
      src_lines_d   = src_lines_q;
      acc_d         = acc_q;
      lcnt_d        = lcnt_q;
      line_start_d  = 1'b0;
      frame_done_d  = 1'b0;
      line_active_d = line_active_q;
      src_line_d    = src_line_q;
      vpos_d        = vpos_q;
      if (vsync_i) begin
         vstart_d      = cfg_vstart;
         vactive_d     = cfg_vactive;
         vinc_d        = (cfg_vinc == '0) ? 16'h0100 : cfg_vinc;
         src_lines_d   = cfg_src_lines;
         acc_d         = {{SRC_W{1'b0}}, cfg_vphase};
         lcnt_d        = '0;
         line_active_d = 1'b0;
      end else if (line_go) begin
         src_line_d    = pos_clamped[ACC_W-1:8];
         vpos_d        = pos_clamped[7:0];
         line_start_d  = 1'b1;
         line_active_d = 1'b1;
         acc_d         = sat_add(acc_q, vinc_q);
         lcnt_d        = start_hit ? 11'd1 : lcnt_q + 11'd1;
      end else if (term) begin
         line_active_d = 1'b0;
         frame_done_d  = 1'b1;
         lcnt_d        = '0;
      end else if (hs_evt && (state_q == S_VBLANK)) begin
         lcnt_d        = lcnt_q + 11'd1;
      end
   end

   always_ff @(posedge mclk or negedge nrst) begin
      if (!nrst) begin
         vstart_q      <= '0;
         vactive_q     <= '0;
         vinc_q        <= '0;
         src_lines_q   <= '0;
         acc_q         <= '0;
         lcnt_q        <= '0;
         line_start_q  <= 1'b0;
         line_active_q <= 1'b0;
         frame_done_q  <= 1'b0;
         src_line_q    <= '0;
         vpos_q        <= '0;
      end else begin
         vstart_q      <= vstart_d;
         vactive_q     <= vactive_d;
         vinc_q        <= vinc_d;
         src_lines_q   <= src_lines_d;
         acc_q         <= acc_d;
         lcnt_q        <= lcnt_d;
         line_start_q  <= line_start_d;
         line_active_q <= line_active_d;
         frame_done_q  <= frame_done_d;
         src_line_q    <= src_line_d;
         vpos_q        <= vpos_d;
      end
   end

   assign line_start_o     = line_start_q;
   assign line_active_o    = line_active_q;
   assign frame_done_o     = frame_done_q;
   assign src_line_o       = src_line_q;
   assign scale_vpos_rel_o = vpos_q;

endmodule

// File: tb/tb_scaler_vpos_gen.sv
// Bench for scaler_vpos_gen: directed scenarios plus randomized frames, all checked
// against a frame-level model (active line i sits at vphase + i*vinc, then clamped).
module tb_scaler_vpos_gen;

   localparam int SRC_W = 10;
   localparam longint ACC_MAX = (64'd1 << (SRC_W + 8)) - 1;

   logic             mclk = 1'b0;
   logic             nrst = 1'b0;
   logic             vsync_i = 1'b0;
   logic             hsync_i = 1'b0;
   logic [10:0]      cfg_vstart = '0;
   logic [10:0]      cfg_vactive = '0;
   logic [15:0]      cfg_vinc = '0;
   logic [7:0]       cfg_vphase = '0;
   logic [SRC_W-1:0] cfg_src_lines = '0;
   logic             line_start_o, line_active_o, frame_done_o;
   logic [SRC_W-1:0] src_line_o;
   logic [7:0]       scale_vpos_rel_o;

   int checks = 0;
   int failures = 0;

   // model state
   bit               m_run;
   int               m_k, m_vstart, m_vactive, m_vinc, m_vphase, m_lines;
   logic             e_ls, e_la, e_fd;
   logic [SRC_W-1:0] e_src;
   logic [7:0]       e_vp;

   wire [SRC_W+10:0] dut_v = {line_start_o, line_active_o, frame_done_o, src_line_o, scale_vpos_rel_o};
   wire [SRC_W+10:0] exp_v = {e_ls, e_la, e_fd, e_src, e_vp};

   scaler_vpos_gen #(.SRC_W(SRC_W)) dut (
      .mclk(mclk), .nrst(nrst), .vsync_i(vsync_i), .hsync_i(hsync_i),
      .cfg_vstart(cfg_vstart), .cfg_vactive(cfg_vactive), .cfg_vinc(cfg_vinc),
      .cfg_vphase(cfg_vphase), .cfg_src_lines(cfg_src_lines),
      .line_start_o(line_start_o), .line_active_o(line_active_o),
      .src_line_o(src_line_o), .scale_vpos_rel_o(scale_vpos_rel_o),
      .frame_done_o(frame_done_o)
   );

   always #5 mclk = ~mclk;

   task automatic m_clear();
      m_run = 0; m_k = 0;
      e_ls = 0; e_la = 0; e_fd = 0; e_src = '0; e_vp = '0;
   endtask

   // One clock with the given sync inputs; the model advances on the same edge.
   task automatic tick(input logic vs, input logic hs);
      longint pos;
      int     ip, i;
      vsync_i = vs; hsync_i = hs;
      @(posedge mclk);
      if (!nrst) m_clear();
      else begin
         e_ls = 0; e_fd = 0;
         if (vs) begin
            m_run = 1; m_k = 0;
            m_vstart = cfg_vstart; m_vactive = cfg_vactive; m_vphase = cfg_vphase;
            m_vinc = (cfg_vinc == 0) ? 256 : cfg_vinc; m_lines = cfg_src_lines;
            e_la = 0;
         end else if (hs && m_run) begin
            m_k++;
            if (m_k == m_vstart + m_vactive + 1) begin
               e_fd = 1; e_la = 0; m_run = 0;
            end else if (m_k > m_vstart) begin
               i = m_k - m_vstart - 1;
               pos = longint'(m_vphase) + longint'(i) * longint'(m_vinc);
               if (pos > ACC_MAX) pos = ACC_MAX;
               ip = int'(pos / 256);
               if (m_lines == 0) begin e_src = '0; e_vp = '0; end
               else if (ip >= m_lines - 1) begin e_src = SRC_W'(m_lines - 1); e_vp = 8'h00; end
               else begin e_src = SRC_W'(ip); e_vp = 8'(pos % 256); end
               e_ls = 1; e_la = 1;
            end
         end
      end
      #1;
      vsync_i = 0; hsync_i = 0;
   endtask

   task automatic set_cfg(input int vs, input int va, input int vi, input int ph, input int sl);
      cfg_vstart = 11'(vs); cfg_vactive = 11'(va); cfg_vinc = 16'(vi);
      cfg_vphase = 8'(ph); cfg_src_lines = SRC_W'(sl);
   endtask

   task automatic test_reset();
      m_clear();
      nrst = 0;
      for (int c = 0; c < 3; c++) begin
         tick(0, c[0]);
         checks++;
         if (dut_v !== '0) begin
            failures++; $display("FAIL reset_hold c=%0d got=%h exp=0", c, dut_v);
         end
      end
      #2 nrst = 1;
      set_cfg(0, 4, 256, 0, 100);
      for (int c = 0; c < 4; c++) begin
         tick(0, 1);
         checks++;
         if (dut_v !== exp_v || line_start_o !== 1'b0) begin
            failures++; $display("FAIL idle_no_line c=%0d got=%h exp=%h", c, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_unity();
      logic [SRC_W-1:0] want;
      set_cfg(2, 4, 16'h0100, 0, 240);
      tick(1, 0);
      for (int h = 1; h <= 8; h++) begin
         tick(0, 1);
         want = SRC_W'(h - 3);
         checks++;
         if (dut_v !== exp_v || line_start_o !== (h >= 3 && h <= 6) || frame_done_o !== (h == 7) ||
             ((h >= 3 && h <= 6) && (src_line_o !== want || scale_vpos_rel_o !== 8'h00))) begin
            failures++; $display("FAIL unity h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
         tick(0, 0);
         checks++;
         if (dut_v !== exp_v || line_start_o !== 1'b0 || frame_done_o !== 1'b0) begin
            failures++; $display("FAIL unity_gap h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back_upscale();
      logic [17:0] tab [4];
      tab = '{{10'd0, 8'h40}, {10'd0, 8'hC0}, {10'd1, 8'h40}, {10'd1, 8'hC0}};
      set_cfg(0, 4, 16'h0080, 8'h40, 240);
      tick(1, 0);
      for (int h = 0; h < 6; h++) begin
         tick(0, 1);
         checks++;
         if (dut_v !== exp_v || (h < 4 && ({src_line_o, scale_vpos_rel_o} !== tab[h] || line_start_o !== 1'b1)) ||
             (h == 4 && frame_done_o !== 1'b1)) begin
            failures++; $display("FAIL upscale h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_clamp();
      logic [SRC_W-1:0] tab [4];
      tab = '{10'd0, 10'd3, 10'd4, 10'd4};
      set_cfg(0, 4, 16'h0300, 0, 5);
      tick(1, 0);
      for (int h = 0; h < 5; h++) begin
         tick(0, 1);
         checks++;
         if (dut_v !== exp_v || (h < 4 && (src_line_o !== tab[h] || scale_vpos_rel_o !== 8'h00))) begin
            failures++; $display("FAIL clamp h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_vsync_hsync_same();
      set_cfg(0, 6, 16'h0100, 8'h20, 240);
      tick(1, 0);
      for (int h = 0; h < 3; h++) tick(0, 1);
      tick(1, 1);
      checks++;
      if (dut_v !== exp_v || line_start_o !== 1'b0) begin
         failures++; $display("FAIL vs_hs_same got=%h exp=%h", dut_v, exp_v);
      end
      tick(0, 1);
      checks++;
      if (dut_v !== exp_v || src_line_o !== '0 || scale_vpos_rel_o !== 8'h20 || line_start_o !== 1'b1) begin
         failures++; $display("FAIL vs_restart got=%h exp=%h", dut_v, exp_v);
      end
   endtask

   task automatic test_cfg_change();
      set_cfg(0, 5, 16'h0100, 0, 240);
      tick(1, 0);
      for (int h = 0; h < 5; h++) begin
         if (h == 2) cfg_vinc = 16'h0200;
         tick(0, 1);
         checks++;
         if (dut_v !== exp_v || src_line_o !== SRC_W'(h)) begin
            failures++; $display("FAIL cfg_hold h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
      end
      tick(1, 0);
      for (int h = 0; h < 3; h++) begin
         tick(0, 1);
         checks++;
         if (dut_v !== exp_v || src_line_o !== SRC_W'(2 * h)) begin
            failures++; $display("FAIL cfg_new h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_cfg(0, 8, 16'h0100, 8'h10, 240);
      tick(1, 0);
      tick(0, 1); tick(0, 1);
      #2 nrst = 0;
      m_clear();
      #1;
      checks++;
      if (dut_v !== '0) begin
         failures++; $display("FAIL reset_async got=%h exp=0", dut_v);
      end
      tick(0, 1);
      #2 nrst = 1;
      for (int h = 0; h < 3; h++) begin
         tick(0, 1);
         checks++;
         if (dut_v !== exp_v || line_start_o !== 1'b0) begin
            failures++; $display("FAIL reset_idle h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
      end
      tick(1, 0);
      tick(0, 1);
      checks++;
      if (dut_v !== exp_v || line_start_o !== 1'b1 || src_line_o !== '0) begin
         failures++; $display("FAIL reset_restart got=%h exp=%h", dut_v, exp_v);
      end
   endtask

   task automatic test_vinc_zero();
      set_cfg(1, 3, 0, 8'h10, 240);
      tick(1, 0);
      for (int h = 0; h < 5; h++) begin
         tick(0, 1);
         checks++;
         if (dut_v !== exp_v || (h >= 1 && h <= 3 && (src_line_o !== SRC_W'(h - 1) || scale_vpos_rel_o !== 8'h10))) begin
            failures++; $display("FAIL vinc_zero h=%0d got=%h exp=%h", h, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_random();
      int nh;
      for (int f = 0; f < 40; f++) begin
         set_cfg($urandom_range(0, 4), $urandom_range(0, 9),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, 16'h0400),
                 $urandom_range(0, 255),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1023));
         tick(1, 0);
         nh = int'(cfg_vstart) + int'(cfg_vactive) + 3;
         for (int h = 0; h < nh; h++) begin
            if ($urandom_range(0, 2) == 0) cfg_vinc = 16'($urandom);
            tick(($urandom_range(0, 30) == 0) ? 1'b1 : 1'b0, 1'b1);
            checks++;
            if (dut_v !== exp_v) begin
               failures++; $display("FAIL random f=%0d h=%0d got=%h exp=%h", f, h, dut_v, exp_v);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
               tick(0, 0);
               checks++;
               if (dut_v !== exp_v) begin
                  failures++; $display("FAIL random_gap f=%0d h=%0d got=%h exp=%h", f, h, dut_v, exp_v);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_back_to_back_upscale();
      test_clamp();
      test_vsync_hsync_same();
      test_cfg_change();
      test_reset_mid();
      test_vinc_zero();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
